z80_ram_arbiter: RTL and testbench
==================================

Name: z80_ram_arbiter

Overview:
- Sequences the shared 8 KB Z80 sound RAM between two requesters: the M68K bus-side port and the Z80 bus-side port.
- Also owns the Z80 BUSREQ register at A11100 and synchronises the Z80 BUSACK response.
- Each requester posts single-cycle command pulses into a one-deep pending slot. The block grants the synchronous RAM round-robin and returns a one-cycle ack, with read data for reads.
- Sits between the bus decode logic and the RAM macro (RAM_en/RAM_we/RAM_addr style port).

Parameters:
- ADDR_W, 13, RAM address width (8 KB).
- DATA_W, 8, RAM data width.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- m68_req  in  1  one-cycle command pulse from the M68K side.
- m68_we  in  1  1 = write, 0 = read; sampled with m68_req.
- m68_addr  in  ADDR_W  address; sampled with m68_req.
- m68_wdata  in  DATA_W  write data; sampled with m68_req.
- m68_ack  out  1  one-cycle completion pulse.
- m68_rdata  out  DATA_W  read data; valid while m68_ack=1, held until the next M68K read completes.
- z80_req, z80_we, z80_addr, z80_wdata, z80_ack, z80_rdata: same widths and meanings as the M68K set, for the Z80 side.
- busreq_wr  in  1  M68K write strobe to A11100.
- busreq_val  in  1  data bit 8 of that write; 1 = request the Z80 bus.
- z80_busreq_n  out  1  BUSREQ to the Z80, active-low.
- z80_busack_n  in  1  BUSACK from the Z80, asynchronous, active-low.
- busack_status  out  1  synchronised BUSACK; 0 = bus granted to the M68K; readable at A11100 bit 8.
- ram_en  out  1  RAM enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data; valid one cycle after ram_en with ram_we=0.

Behaviour:
- Reset values, rst high at a posedge:
  - state=IDLE; both pending slots cleared; last_grant=Z80.
  - ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0.
  - m68_ack=0, z80_ack=0, m68_rdata=0, z80_rdata=0.
  - z80_busreq_n=1; busack sync flops=1, so busack_status=1.
- Reset mid-operation: any access in flight is abandoned. No ack is issued, and ram_en is 0 from the next cycle.
- Pending slots, per side:
  - A req pulse while the slot is empty captures we/addr/wdata and sets pending.
  - A req while pending=1 is ignored; this is a protocol violation and the bus decode guarantees it does not happen.
  - A req in the same cycle as that side's ack is accepted as the new command.
- BUSREQ register:
  - busreq_wr=1 sets z80_busreq_n <= ~busreq_val on the next cycle.
  - busack_status is z80_busack_n through a 2-flop synchroniser, so it has 2 cycles of latency.
- Eligibility:
  - M68K pending is eligible always.
  - Z80 pending is eligible only when busack_status=1, i.e. the Z80 owns its bus. Otherwise it waits in its slot with no timeout.
  - An M68K access while busack_status=1 (bus not granted) is a dummy access: no RAM cycle, m68_rdata=8'hFF, and the ack is given at normal latency. Writes are dropped.
- State machine (IDLE, ACCESS, COMPLETE):
  - IDLE:
    - If both sides are eligible, grant the side opposite last_grant.
    - Otherwise grant the single eligible side.
    - On a grant: register ram_en=1 (unless dummy), ram_we, ram_addr, ram_wdata; set last_grant; go to ACCESS.
    - With no eligible side, stay in IDLE with ram_en=0.
  - ACCESS: ram_en <= 0, ram_we <= 0; go to COMPLETE.
  - COMPLETE:
    - Capture ram_rdata, or 8'hFF for a dummy access, into the granted side's rdata (reads only).
    - Pulse that side's ack, clear its pending, go to IDLE.
- Latency:
  - A req at cycle N into an idle arbiter gives ram_en high during N+1 and the ack at N+3.
  - Throughput is one access per 3 cycles.
  - Worst case with a competing request is 6 cycles.
- Write rdata: unchanged on write completion.
- Bus grant change mid-access: the access already granted completes normally. Eligibility is evaluated only in IDLE.

Test Plan:
- Reset then idle: rst 2 cycles -> all outputs at reset values; z80_busreq_n=1; no ram_en activity for 20 cycles.
- Z80 read: busack_n=1, z80_req we=0 addr=13'h0100, RAM holds 8'h5A -> ram_en at N+1, z80_ack at N+3, z80_rdata=8'h5A.
- M68K without grant: m68_req write 8'h33 to 13'h0200 with busack_status=1 -> no ram_en; m68_ack at N+3. A subsequent granted read of 13'h0200 returns the old value, and an ungranted read returns 8'hFF.
- Bus grant: busreq_wr val=1 -> z80_busreq_n=0 next cycle. Drive z80_busack_n=0 -> busack_status=0 two cycles later. M68K write 8'hA5 to 13'h1FFF, then read back -> 8'hA5. A pending Z80 req stays pending (no z80_ack) until busreq_val=0 and busack_n returns to 1.
- Simultaneous requests: both req together at N with busack_n=1 after reset -> M68K dummy access acked at N+3, Z80 acked at N+6. A repeat of both requests gives the same order, alternating from last_grant (Z80 was last, so M68K wins the tie).
- Reset mid-access: rst asserted in ACCESS -> no ack either side; pending cleared; ram_en=0; the next req completes at normal latency.

Source files
------------

// File: rtl/z80_ram_arbiter.sv
// rtl/z80_ram_arbiter.sv - round-robin arbiter for the shared Z80 sound RAM
// Also holds the A11100 BUSREQ register and synchronises BUSACK from the Z80.
module z80_ram_arbiter #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m68_req,
    input  logic              m68_we,
    input  logic [ADDR_W-1:0] m68_addr,
    input  logic [DATA_W-1:0] m68_wdata,
    output logic              m68_ack,
    output logic [DATA_W-1:0] m68_rdata,
    input  logic              z80_req,
    input  logic              z80_we,
    input  logic [ADDR_W-1:0] z80_addr,
    input  logic [DATA_W-1:0] z80_wdata,
    output logic              z80_ack,
    output logic [DATA_W-1:0] z80_rdata,
    input  logic              busreq_wr,
    input  logic              busreq_val,
    output logic              z80_busreq_n,
    input  logic              z80_busack_n,
    output logic              busack_status,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_COMPLETE
    } state_t;

    state_t state_q, state_d;

    logic              m68_pend_q, m68_pend_d;
    logic              m68_pwe_q, m68_pwe_d;
    logic [ADDR_W-1:0] m68_paddr_q, m68_paddr_d;
    logic [DATA_W-1:0] m68_pwdata_q, m68_pwdata_d;
    logic              z80_pend_q, z80_pend_d;
    logic              z80_pwe_q, z80_pwe_d;
    logic [ADDR_W-1:0] z80_paddr_q, z80_paddr_d;
    logic [DATA_W-1:0] z80_pwdata_q, z80_pwdata_d;

    logic              last_z80_q, last_z80_d;
    logic              grant_z80_q, grant_z80_d;
    logic              gnt_we_q, gnt_we_d;
    logic              dummy_q, dummy_d;

    logic              ram_en_q, ram_en_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;

    logic              m68_ack_q, m68_ack_d;
    logic              z80_ack_q, z80_ack_d;
    logic [DATA_W-1:0] m68_rdata_q, m68_rdata_d;
    logic [DATA_W-1:0] z80_rdata_q, z80_rdata_d;

    logic              busreq_n_q, busreq_n_d;
    logic              busack_meta_q, busack_meta_d;
    logic              busack_sync_q, busack_sync_d;

    // A request arriving in an idle cycle is arbitrated directly from the
    // inputs so the RAM cycle starts on the very next clock.
    logic              m68_has;
    logic              z80_elig;
    logic              m68_ewe, z80_ewe;
    logic [ADDR_W-1:0] m68_eaddr, z80_eaddr;
    logic [DATA_W-1:0] m68_ewdata, z80_ewdata;
    logic              pick_z80;

    always_comb begin
        m68_has    = m68_pend_q | m68_req;
        z80_elig   = (z80_pend_q | z80_req) & busack_sync_q;
        m68_ewe    = m68_pend_q ? m68_pwe_q    : m68_we;
        m68_eaddr  = m68_pend_q ? m68_paddr_q  : m68_addr;
        m68_ewdata = m68_pend_q ? m68_pwdata_q : m68_wdata;
        z80_ewe    = z80_pend_q ? z80_pwe_q    : z80_we;
        z80_eaddr  = z80_pend_q ? z80_paddr_q  : z80_addr;
        z80_ewdata = z80_pend_q ? z80_pwdata_q : z80_wdata;
    end

    always_comb begin
        state_d       = state_q;
        m68_pend_d    = m68_pend_q;
        m68_pwe_d     = m68_pwe_q;
        m68_paddr_d   = m68_paddr_q;
        m68_pwdata_d  = m68_pwdata_q;
        z80_pend_d    = z80_pend_q;
        z80_pwe_d     = z80_pwe_q;
        z80_paddr_d   = z80_paddr_q;
        z80_pwdata_d  = z80_pwdata_q;
        last_z80_d    = last_z80_q;
        grant_z80_d   = grant_z80_q;
        gnt_we_d      = gnt_we_q;
        dummy_d       = dummy_q;
        ram_en_d      = ram_en_q;
        ram_we_d      = ram_we_q;
        ram_addr_d    = ram_addr_q;
        ram_wdata_d   = ram_wdata_q;
        m68_ack_d     = 1'b0;
        z80_ack_d     = 1'b0;
        m68_rdata_d   = m68_rdata_q;
        z80_rdata_d   = z80_rdata_q;
        busreq_n_d    = busreq_wr ? ~busreq_val : busreq_n_q;
        busack_meta_d = z80_busack_n;
        busack_sync_d = busack_meta_q;
        pick_z80      = 1'b0;

        if (m68_req && !m68_pend_q) begin
            m68_pend_d   = 1'b1;
            m68_pwe_d    = m68_we;
            m68_paddr_d  = m68_addr;
            m68_pwdata_d = m68_wdata;
        end
        if (z80_req && !z80_pend_q) begin
            z80_pend_d   = 1'b1;
            z80_pwe_d    = z80_we;
            z80_paddr_d  = z80_addr;
            z80_pwdata_d = z80_wdata;
        end

        case (state_q)
            S_IDLE: begin
                ram_en_d = 1'b0;
                ram_we_d = 1'b0;
                if (m68_has || z80_elig) begin
                    pick_z80    = z80_elig && (!m68_has || !last_z80_q);
                    state_d     = S_ACCESS;
                    grant_z80_d = pick_z80;
                    last_z80_d  = pick_z80;
                    if (pick_z80) begin
                        dummy_d     = 1'b0;
                        gnt_we_d    = z80_ewe;
                        ram_en_d    = 1'b1;
                        ram_we_d    = z80_ewe;
                        ram_addr_d  = z80_eaddr;
                        ram_wdata_d = z80_ewdata;
                    end else begin
                        // Without the bus grant the M68K side sees open bus.
                        dummy_d     = busack_sync_q;
                        gnt_we_d    = m68_ewe;
                        ram_en_d    = ~busack_sync_q;
                        ram_we_d    = m68_ewe & ~busack_sync_q;
                        ram_addr_d  = m68_eaddr;
                        ram_wdata_d = m68_ewdata;
                    end
                end
            end
            S_ACCESS: begin
                ram_en_d = 1'b0;
                ram_we_d = 1'b0;
                state_d  = S_COMPLETE;
            end
            S_COMPLETE: begin
                state_d = S_IDLE;
                if (grant_z80_q) begin
                    z80_ack_d  = 1'b1;
                    z80_pend_d = 1'b0;
                    if (!gnt_we_q) begin
                        z80_rdata_d = ram_rdata;
                    end
                end else begin
                    m68_ack_d  = 1'b1;
                    m68_pend_d = 1'b0;
                    if (!gnt_we_q) begin
                        m68_rdata_d = dummy_q ? {DATA_W{1'b1}} : ram_rdata;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            m68_pend_q    <= 1'b0;
            m68_pwe_q     <= 1'b0;
            m68_paddr_q   <= '0;
            m68_pwdata_q  <= '0;
            z80_pend_q    <= 1'b0;
            z80_pwe_q     <= 1'b0;
            z80_paddr_q   <= '0;
            z80_pwdata_q  <= '0;
            last_z80_q    <= 1'b1;
            grant_z80_q   <= 1'b0;
            gnt_we_q      <= 1'b0;
            dummy_q       <= 1'b0;
            ram_en_q      <= 1'b0;
            ram_we_q      <= 1'b0;
            ram_addr_q    <= '0;
            ram_wdata_q   <= '0;
            m68_ack_q     <= 1'b0;
            z80_ack_q     <= 1'b0;
            m68_rdata_q   <= '0;
            z80_rdata_q   <= '0;
            busreq_n_q    <= 1'b1;
            busack_meta_q <= 1'b1;
            busack_sync_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            m68_pend_q    <= m68_pend_d;
            m68_pwe_q     <= m68_pwe_d;
            m68_paddr_q   <= m68_paddr_d;
            m68_pwdata_q  <= m68_pwdata_d;
            z80_pend_q    <= z80_pend_d;
            z80_pwe_q     <= z80_pwe_d;
            z80_paddr_q   <= z80_paddr_d;
            z80_pwdata_q  <= z80_pwdata_d;
            last_z80_q    <= last_z80_d;
            grant_z80_q   <= grant_z80_d;
            gnt_we_q      <= gnt_we_d;
            dummy_q       <= dummy_d;
            ram_en_q      <= ram_en_d;
            ram_we_q      <= ram_we_d;
            ram_addr_q    <= ram_addr_d;
            ram_wdata_q   <= ram_wdata_d;
            m68_ack_q     <= m68_ack_d;
            z80_ack_q     <= z80_ack_d;
            m68_rdata_q   <= m68_rdata_d;
            z80_rdata_q   <= z80_rdata_d;
            busreq_n_q    <= busreq_n_d;
            busack_meta_q <= busack_meta_d;
            busack_sync_q <= busack_sync_d;
        end
    end

    assign m68_ack       = m68_ack_q;
    assign m68_rdata     = m68_rdata_q;
    assign z80_ack       = z80_ack_q;
    assign z80_rdata     = z80_rdata_q;
    assign z80_busreq_n  = busreq_n_q;
    assign busack_status = busack_sync_q;
    assign ram_en        = ram_en_q;
    assign ram_we        = ram_we_q;
    assign ram_addr      = ram_addr_q;
    assign ram_wdata     = ram_wdata_q;

endmodule

// File: tb/tb_z80_ram_arbiter.sv
// tb/tb_z80_ram_arbiter.sv - self-checking bench for z80_ram_arbiter
module tb_z80_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m68_req = 1'b0, m68_we = 1'b0;
    logic [12:0] m68_addr = '0;
    logic [7:0]  m68_wdata = '0;
    logic        m68_ack;
    logic [7:0]  m68_rdata;
    logic        z80_req = 1'b0, z80_we = 1'b0;
    logic [12:0] z80_addr = '0;
    logic [7:0]  z80_wdata = '0;
    logic        z80_ack;
    logic [7:0]  z80_rdata;
    logic        busreq_wr = 1'b0, busreq_val = 1'b0;
    logic        z80_busreq_n;
    logic        z80_busack_n = 1'b1;
    logic        busack_status;
    logic        ram_en, ram_we;
    logic [12:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    int n_chk = 0;
    int n_fail = 0;
    int ram_en_cnt = 0;
    bit granted = 1'b0;

    z80_ram_arbiter #(.ADDR_W(13), .DATA_W(8)) dut (
        .clk(clk), .rst(rst),
        .m68_req(m68_req), .m68_we(m68_we), .m68_addr(m68_addr), .m68_wdata(m68_wdata),
        .m68_ack(m68_ack), .m68_rdata(m68_rdata),
        .z80_req(z80_req), .z80_we(z80_we), .z80_addr(z80_addr), .z80_wdata(z80_wdata),
        .z80_ack(z80_ack), .z80_rdata(z80_rdata),
        .busreq_wr(busreq_wr), .busreq_val(busreq_val), .z80_busreq_n(z80_busreq_n),
        .z80_busack_n(z80_busack_n), .busack_status(busack_status),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(input logic [12:0] a);
        return a[7:0] ^ {a[12:8], 3'b101};
    endfunction

    // Synchronous RAM macro: read data appears the cycle after ram_en.
    logic [7:0] mem   [0:8191];
    logic       mem_v [0:8191];
    always @(posedge clk) begin
        if (ram_en === 1'b1) begin
            ram_en_cnt <= ram_en_cnt + 1;
            if (ram_we) begin
                mem[ram_addr]   <= ram_wdata;
                mem_v[ram_addr] <= 1'b1;
            end else begin
                ram_rdata <= (mem_v[ram_addr] === 1'b1) ? mem[ram_addr] : init_val(ram_addr);
            end
        end
    end

    logic [7:0] ref_w [int];

    function automatic logic [7:0] ref_rd(input logic [12:0] a);
        if (ref_w.exists(int'(a))) return ref_w[int'(a)];
        return init_val(a);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        busreq_wr = 1'b0;
        z80_busack_n = 1'b1;
        granted = 1'b0;
        rst = 1'b1;
        repeat (n) step();
        rst = 1'b0;
    endtask

    task automatic set_grant(input bit g);
        busreq_wr = 1'b1;
        busreq_val = g;
        step();
        busreq_wr = 1'b0;
        z80_busack_n = ~g;
        step();
        step();
        granted = g;
    endtask

    task automatic access(input bit side, input bit we, input logic [12:0] a, input logic [7:0] d,
                          output int lat, output logic [7:0] rd, output int ens, output logic en1);
        int c0;
        c0 = ram_en_cnt;
        lat = -1;
        rd = 'x;
        if (side) begin
            z80_req = 1'b1; z80_we = we; z80_addr = a; z80_wdata = d;
        end else begin
            m68_req = 1'b1; m68_we = we; m68_addr = a; m68_wdata = d;
        end
        step();
        z80_req = 1'b0;
        m68_req = 1'b0;
        en1 = ram_en;
        for (int k = 1; k <= 12 && lat < 0; k++) begin
            if (k > 1) step();
            if ((side ? z80_ack : m68_ack) === 1'b1) begin
                lat = k;
                rd = side ? z80_rdata : m68_rdata;
            end
        end
        ens = ram_en_cnt - c0;
    endtask

    task automatic test_reset();
        int c0, acks;
        rst = 1'b1;
        step();
        step();
        n_chk++; if (ram_en !== 1'b0) begin n_fail++; $display("FAIL reset_ram_en got %b want 0", ram_en); end
        n_chk++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL reset_ram_we got %b want 0", ram_we); end
        n_chk++; if (ram_addr !== 13'h0) begin n_fail++; $display("FAIL reset_ram_addr got %h want 0", ram_addr); end
        n_chk++; if (ram_wdata !== 8'h0) begin n_fail++; $display("FAIL reset_ram_wdata got %h want 0", ram_wdata); end
        n_chk++; if (m68_ack !== 1'b0 || z80_ack !== 1'b0) begin n_fail++; $display("FAIL reset_acks got %b%b want 00", m68_ack, z80_ack); end
        n_chk++; if (m68_rdata !== 8'h0) begin n_fail++; $display("FAIL reset_m68_rdata got %h want 0", m68_rdata); end
        n_chk++; if (z80_rdata !== 8'h0) begin n_fail++; $display("FAIL reset_z80_rdata got %h want 0", z80_rdata); end
        n_chk++; if (z80_busreq_n !== 1'b1) begin n_fail++; $display("FAIL reset_busreq_n got %b want 1", z80_busreq_n); end
        n_chk++; if (busack_status !== 1'b1) begin n_fail++; $display("FAIL reset_busack got %b want 1", busack_status); end
        rst = 1'b0;
        c0 = ram_en_cnt;
        acks = 0;
        repeat (20) begin
            step();
            if (m68_ack !== 1'b0 || z80_ack !== 1'b0) acks++;
        end
        n_chk++; if (ram_en_cnt - c0 != 0) begin n_fail++; $display("FAIL idle_ram_en got %0d cycles want 0", ram_en_cnt - c0); end
        n_chk++; if (acks != 0) begin n_fail++; $display("FAIL idle_acks got %0d want 0", acks); end
    endtask

    task automatic test_z80_read();
        int lat, ens;
        logic [7:0] rd;
        logic en1;
        access(1'b1, 1'b1, 13'h0100, 8'h5A, lat, rd, ens, en1);
        ref_w[32'h100] = 8'h5A;
        n_chk++; if (lat != 3 || ens != 1) begin n_fail++; $display("FAIL z80_write lat %0d ens %0d want 3 1", lat, ens); end
        access(1'b1, 1'b0, 13'h0100, 8'h00, lat, rd, ens, en1);
        n_chk++; if (en1 !== 1'b1) begin n_fail++; $display("FAIL z80_read_en_n1 got %b want 1", en1); end
        n_chk++; if (lat != 3) begin n_fail++; $display("FAIL z80_read_lat got %0d want 3", lat); end
        n_chk++; if (rd !== 8'h5A) begin n_fail++; $display("FAIL z80_read_data got %h want 5a", rd); end
    endtask

    task automatic test_m68_no_grant();
        int lat, ens;
        logic [7:0] rd;
        logic en1;
        access(1'b0, 1'b1, 13'h0200, 8'h33, lat, rd, ens, en1);
        n_chk++; if (lat != 3) begin n_fail++; $display("FAIL nogrant_wr_lat got %0d want 3", lat); end
        n_chk++; if (ens != 0 || en1 !== 1'b0) begin n_fail++; $display("FAIL nogrant_wr_ram_en got %0d want 0", ens); end
        set_grant(1'b1);
        access(1'b0, 1'b0, 13'h0200, 8'h00, lat, rd, ens, en1);
        n_chk++; if (lat != 3 || ens != 1) begin n_fail++; $display("FAIL grant_rd lat %0d ens %0d want 3 1", lat, ens); end
        n_chk++; if (rd !== ref_rd(13'h0200)) begin n_fail++; $display("FAIL grant_rd_old got %h want %h", rd, ref_rd(13'h0200)); end
        set_grant(1'b0);
        access(1'b0, 1'b0, 13'h0200, 8'h00, lat, rd, ens, en1);
        n_chk++; if (rd !== 8'hFF || ens != 0) begin n_fail++; $display("FAIL nogrant_rd got %h ens %0d want ff 0", rd, ens); end
    endtask

    task automatic test_bus_grant();
        int lat, ens, c0, zack, zlat;
        logic [7:0] rd, zrd;
        logic en1;
        busreq_wr = 1'b1;
        busreq_val = 1'b1;
        step();
        busreq_wr = 1'b0;
        n_chk++; if (z80_busreq_n !== 1'b0) begin n_fail++; $display("FAIL busreq_set got %b want 0", z80_busreq_n); end
        z80_busack_n = 1'b0;
        step();
        n_chk++; if (busack_status !== 1'b1) begin n_fail++; $display("FAIL busack_early got %b want 1", busack_status); end
        step();
        n_chk++; if (busack_status !== 1'b0) begin n_fail++; $display("FAIL busack_sync got %b want 0", busack_status); end
        granted = 1'b1;
        access(1'b0, 1'b1, 13'h1FFF, 8'hA5, lat, rd, ens, en1);
        ref_w[32'h1FFF] = 8'hA5;
        n_chk++; if (lat != 3 || ens != 1) begin n_fail++; $display("FAIL grant_wr lat %0d ens %0d want 3 1", lat, ens); end
        access(1'b0, 1'b0, 13'h1FFF, 8'h00, lat, rd, ens, en1);
        n_chk++; if (rd !== 8'hA5) begin n_fail++; $display("FAIL grant_readback got %h want a5", rd); end
        c0 = ram_en_cnt;
        zack = 0;
        z80_req = 1'b1; z80_we = 1'b0; z80_addr = 13'h1FFF;
        step();
        z80_req = 1'b0;
        repeat (10) begin
            if (z80_ack === 1'b1) zack++;
            step();
        end
        n_chk++; if (zack != 0 || ram_en_cnt != c0) begin n_fail++; $display("FAIL z80_blocked acks %0d ram_en %0d want 0 0", zack, ram_en_cnt - c0); end
        busreq_wr = 1'b1;
        busreq_val = 1'b0;
        step();
        busreq_wr = 1'b0;
        n_chk++; if (z80_busreq_n !== 1'b1) begin n_fail++; $display("FAIL busreq_clr got %b want 1", z80_busreq_n); end
        z80_busack_n = 1'b1;
        granted = 1'b0;
        zlat = -1;
        zrd = 'x;
        for (int k = 1; k <= 12 && zlat < 0; k++) begin
            step();
            if (z80_ack === 1'b1) begin zlat = k; zrd = z80_rdata; end
        end
        n_chk++; if (zlat < 0) begin n_fail++; $display("FAIL z80_released no ack got timeout want ack"); end
        n_chk++; if (zrd !== 8'hA5) begin n_fail++; $display("FAIL z80_released_data got %h want a5", zrd); end
    endtask

    task automatic test_simultaneous();
        int ml, zl;
        logic [7:0] mr, zr;
        logic [12:0] za;
        do_reset(2);
        for (int r = 0; r < 2; r++) begin
            za = 13'(13'h0400 + r * 7);
            m68_req = 1'b1; m68_we = 1'b0; m68_addr = 13'(13'h0300 + r);
            z80_req = 1'b1; z80_we = 1'b0; z80_addr = za;
            ml = -1; zl = -1; mr = 'x; zr = 'x;
            step();
            m68_req = 1'b0;
            z80_req = 1'b0;
            for (int k = 1; k <= 12; k++) begin
                if (k > 1) step();
                if (m68_ack === 1'b1 && ml < 0) begin ml = k; mr = m68_rdata; end
                if (z80_ack === 1'b1 && zl < 0) begin zl = k; zr = z80_rdata; end
            end
            n_chk++; if (ml != 3) begin n_fail++; $display("FAIL simul%0d_m68_lat got %0d want 3", r, ml); end
            n_chk++; if (zl != 6) begin n_fail++; $display("FAIL simul%0d_z80_lat got %0d want 6", r, zl); end
            n_chk++; if (mr !== 8'hFF) begin n_fail++; $display("FAIL simul%0d_m68_data got %h want ff", r, mr); end
            n_chk++; if (zr !== ref_rd(za)) begin n_fail++; $display("FAIL simul%0d_z80_data got %h want %h", r, zr, ref_rd(za)); end
        end
    endtask

    task automatic test_reset_mid_access();
        int lat, ens, c0, acks;
        logic [7:0] rd;
        logic en1;
        access(1'b0, 1'b0, 13'h0010, 8'h00, lat, rd, ens, en1);
        m68_req = 1'b1; m68_we = 1'b0; m68_addr = 13'h0011;
        z80_req = 1'b1; z80_we = 1'b0; z80_addr = 13'h0020;
        step();
        m68_req = 1'b0;
        z80_req = 1'b0;
        n_chk++; if (ram_en !== 1'b1) begin n_fail++; $display("FAIL midrst_access got ram_en %b want 1", ram_en); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_chk++; if (ram_en !== 1'b0) begin n_fail++; $display("FAIL midrst_ram_en got %b want 0", ram_en); end
        c0 = ram_en_cnt;
        acks = 0;
        repeat (10) begin
            if (m68_ack !== 1'b0 || z80_ack !== 1'b0) acks++;
            step();
        end
        n_chk++; if (acks != 0 || ram_en_cnt != c0) begin n_fail++; $display("FAIL midrst_quiet acks %0d ram_en %0d want 0 0", acks, ram_en_cnt - c0); end
        access(1'b1, 1'b0, 13'h0020, 8'h00, lat, rd, ens, en1);
        n_chk++; if (lat != 3 || rd !== ref_rd(13'h0020)) begin n_fail++; $display("FAIL midrst_next lat %0d data %h want 3 %h", lat, rd, ref_rd(13'h0020)); end
    endtask

    task automatic test_back_to_back_random();
        int lat, ens, exp_ens;
        logic [7:0] rd, d, exp_rd;
        logic [12:0] a;
        logic en1;
        bit side, we, dummy;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 7) == 0) set_grant(~granted);
            side = granted ? 1'b0 : 1'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0: a = 13'h0000;
                1: a = 13'h1FFF;
                default: a = 13'($urandom_range(0, 63));
            endcase
            d = 8'($urandom);
            dummy = !side && !granted;
            exp_rd = dummy ? 8'hFF : ref_rd(a);
            exp_ens = dummy ? 0 : 1;
            access(side, we, a, d, lat, rd, ens, en1);
            if (we && !dummy) ref_w[int'(a)] = d;
            n_chk++; if (lat != 3) begin n_fail++; $display("FAIL rand%0d_lat got %0d want 3", i, lat); end
            n_chk++; if (ens != exp_ens) begin n_fail++; $display("FAIL rand%0d_ram_en got %0d want %0d", i, ens, exp_ens); end
            if (!we) begin
                n_chk++; if (rd !== exp_rd) begin n_fail++; $display("FAIL rand%0d_rdata side %0d addr %h got %h want %h", i, side, a, rd, exp_rd); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_z80_read();
        test_m68_no_grant();
        test_bus_grant();
        test_simultaneous();
        test_reset_mid_access();
        test_back_to_back_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
